// File: rtl/atmega_dbg_pkg.sv
// atmega_dbg_pkg: opcodes, response codes and parser states shared by the debug bridge.
package atmega_dbg_pkg;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA, S_REQ, S_ACCESS, S_RESP
  } state_e;
endpackage

// File: rtl/atmega_dbg_uart_phy.sv
// atmega_dbg_uart_phy: 8N1 byte receiver and transmitter with independent bit timers.
module atmega_dbg_uart_phy #(
  parameter logic [15:0] CLK_DIV = 16'd868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       rx_busy_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       tx_busy_o
);
  logic [2:0]  rx_s_q;
  logic        rx_act_q, tx_act_q, rx_tick;
  logic [15:0] rx_cnt_q, tx_cnt_q;
  logic [3:0]  rx_bit_q, tx_bit_q;
  logic [7:0]  rx_sh_q;
  logic [9:0]  tx_sh_q;
  // rx_s_q[1] is the synchronized line, rx_s_q[2] its previous value; reset to 0
  // so a line held low through reset never looks like a falling edge.
  assign rx_tick   = rx_cnt_q == (rx_bit_q == 4'd0 ? (CLK_DIV >> 1) - 16'd1 : CLK_DIV - 16'd1);
  assign rx_data_o = rx_sh_q;
  assign rx_busy_o = rx_act_q;
  assign tx_o      = tx_sh_q[0];
  assign tx_busy_o = tx_act_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s_q     <= '0;
      rx_act_q   <= 1'b0;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_o <= 1'b0;
      rx_ferr_o  <= 1'b0;
    end else begin
      rx_s_q     <= {rx_s_q[1:0], rx_i};
      rx_valid_o <= 1'b0;
      rx_ferr_o  <= 1'b0;
      if (!rx_act_q) begin
        rx_cnt_q <= '0;
        rx_bit_q <= '0;
        rx_act_q <= rx_s_q[2] && !rx_s_q[1];
      end else if (!rx_tick) begin
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end else begin
        rx_cnt_q <= '0;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) rx_act_q <= !rx_s_q[1];
        else if (rx_bit_q < 4'd9) rx_sh_q <= {rx_s_q[1], rx_sh_q[7:1]};
        else begin
          rx_act_q   <= 1'b0;
          rx_valid_o <= rx_s_q[1];
          rx_ferr_o  <= !rx_s_q[1];
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_act_q <= 1'b0;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '1;
    end else if (!tx_act_q) begin
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      if (tx_start_i) begin
        tx_act_q <= 1'b1;
        tx_sh_q  <= {1'b1, tx_data_i, 1'b0};
      end
    end else if (tx_cnt_q != CLK_DIV - 16'd1) begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end else begin
      tx_cnt_q <= '0;
      tx_bit_q <= tx_bit_q + 4'd1;
      tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
      if (tx_bit_q == 4'd9) tx_act_q <= 1'b0;
    end
  end
endmodule

// File: rtl/atmega_uart_dbg_bridge.sv
// atmega_uart_dbg_bridge: UART command parser that performs single-byte IO/data bus accesses.
module atmega_uart_dbg_bridge
  import atmega_dbg_pkg::*;
#(
  parameter logic [15:0] CLK_DIV           = 16'd868,
  parameter logic [23:0] TIMEOUT_CYC       = 24'd1000000,
  parameter int          BUS_ADDR_IO_LEN   = 16,
  parameter int          BUS_ADDR_DATA_LEN = 8,
  parameter int unsigned IO_ADDR_LIMIT     = 'h40
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic                         rx,
  output logic                         tx,
  output logic                         bus_req,
  input  logic                         bus_gnt,
  output logic [BUS_ADDR_IO_LEN-1:0]   addr_io,
  output logic                         wr_io,
  output logic                         rd_io,
  output logic [7:0]                   io_out,
  input  logic [7:0]                   io_in,
  output logic [BUS_ADDR_DATA_LEN-1:0] addr_dat,
  output logic                         wr_dat,
  output logic                         rd_dat,
  output logic [7:0]                   dat_out,
  input  logic [7:0]                   dat_in,
  output logic                         busy,
  output logic                         err
);
  state_e      state_q, state_d;
  logic        wr_q, wr_d, pend_q, pend_d, err_q, err_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d, txb_q, txb_d, rx_byte;
  logic [23:0] tmo_q, tmo_d;
  logic        rx_vld, rx_ferr, rx_busy, tx_busy, is_io, timed, tmo, nak, sel_io, sel_dat;
  atmega_dbg_uart_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk(clk), .rst(rst), .rx_i(rx), .rx_data_o(rx_byte), .rx_valid_o(rx_vld),
    .rx_ferr_o(rx_ferr), .rx_busy_o(rx_busy), .tx_start_i(pend_q && !tx_busy),
    .tx_data_i(txb_q), .tx_o(tx), .tx_busy_o(tx_busy)
  );
  assign is_io = addr_q < 16'(IO_ADDR_LIMIT);
  assign timed = state_q inside {S_ADDR_H, S_ADDR_L, S_DATA, S_REQ};
  assign tmo   = timed && tmo_q == TIMEOUT_CYC;
  assign err   = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      txb_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      txb_q   <= txb_d;
      tmo_q   <= tmo_d;
    end
  end
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    txb_d   = txb_q;
    pend_d  = pend_q && tx_busy;
    err_d   = rx_ferr;
    nak     = 1'b0;
    case (state_q)
      S_IDLE: if (rx_vld) begin
        nak     = rx_byte != OP_WR && rx_byte != OP_RD;
        wr_d    = rx_byte == OP_WR;
        state_d = S_ADDR_H;
      end
      S_ADDR_H: if (rx_vld) begin
        addr_d[15:8] = rx_byte;
        state_d      = S_ADDR_L;
      end else nak = tmo;
      S_ADDR_L: if (rx_vld) begin
        addr_d[7:0] = rx_byte;
        state_d     = wr_q ? S_DATA : S_REQ;
      end else nak = tmo;
      S_DATA: if (rx_vld) begin
        data_d  = rx_byte;
        state_d = S_REQ;
      end else nak = tmo;
      S_REQ: begin
        err_d   = err_d || rx_vld;
        state_d = bus_gnt ? S_ACCESS : state_q;
        nak     = !bus_gnt && tmo;
      end
      S_ACCESS: begin
        err_d   = err_d || rx_vld;
        state_d = S_RESP;
        pend_d  = 1'b1;
        txb_d   = wr_q ? RSP_ACK : is_io ? io_in : dat_in;
      end
      default: begin
        err_d   = err_d || rx_vld;
        state_d = !pend_q && !tx_busy ? S_IDLE : state_q;
      end
    endcase
    if (nak) begin
      state_d = S_IDLE;
      pend_d  = 1'b1;
      txb_d   = RSP_NAK;
      err_d   = 1'b1;
    end
    if (rx_ferr && state_q inside {S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA}) state_d = S_IDLE;
    // Idle time only: a byte being shifted in does not count toward the frame timeout.
    tmo_d = timed && state_d == state_q && !(rx_busy && state_q != S_REQ) ? tmo_q + 24'd1 : '0;
  end
  always_comb begin
    sel_io   = state_q == S_ACCESS && is_io;
    sel_dat  = state_q == S_ACCESS && !is_io;
    bus_req  = state_q == S_REQ || state_q == S_ACCESS;
    addr_io  = sel_io ? addr_q[BUS_ADDR_IO_LEN-1:0] : '0;
    wr_io    = sel_io && wr_q;
    rd_io    = sel_io && !wr_q;
    io_out   = sel_io && wr_q ? data_q : '0;
    addr_dat = sel_dat ? addr_q[BUS_ADDR_DATA_LEN-1:0] : '0;
    wr_dat   = sel_dat && wr_q;
    rd_dat   = sel_dat && !wr_q;
    dat_out  = sel_dat && wr_q ? data_q : '0;
    busy     = state_q != S_IDLE || pend_q || tx_busy;
  end
endmodule

// File: tb/tb_atmega_uart_dbg_bridge.sv
// tb_atmega_uart_dbg_bridge: directed scenarios for the UART debug bridge at CLK_DIV=16, TIMEOUT_CYC=100.
module tb_atmega_uart_dbg_bridge;
  logic clk = 0, rst = 1, rx = 0, bus_gnt = 1;
  logic [7:0] io_in = 0, dat_in = 0;
  logic tx, bus_req, wr_io, rd_io, wr_dat, rd_dat, busy, err;
  logic [15:0] addr_io;
  logic [7:0] addr_dat, io_out, dat_out;
  int n_chk = 0, n_fail = 0;
  int n_wr_io = 0, n_rd_io = 0, n_wr_dat = 0, n_rd_dat = 0, n_err = 0, viol = 0, rst_gen = 0;
  logic [15:0] la_io = 0;
  logic [7:0] lo_io = 0, la_dat = 0, lo_dat = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  atmega_uart_dbg_bridge #(.CLK_DIV(16'd16), .TIMEOUT_CYC(24'd100)) dut (
    .rst(rst), .clk(clk), .rx(rx), .tx(tx), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .addr_io(addr_io), .wr_io(wr_io), .rd_io(rd_io), .io_out(io_out), .io_in(io_in),
    .addr_dat(addr_dat), .wr_dat(wr_dat), .rd_dat(rd_dat), .dat_out(dat_out), .dat_in(dat_in),
    .busy(busy), .err(err)
  );

  always @(posedge rst) rst_gen++;

  always @(negedge clk) begin
    if (err) n_err++;
    if (wr_io) begin n_wr_io++; la_io = addr_io; lo_io = io_out; end
    if (rd_io) begin n_rd_io++; la_io = addr_io; end
    if (wr_dat) begin n_wr_dat++; la_dat = addr_dat; lo_dat = dat_out; end
    if (rd_dat) begin n_rd_dat++; la_dat = addr_dat; end
    if (!(wr_io || rd_io) && (addr_io != 0 || io_out != 0)) viol++;
    if (!(wr_dat || rd_dat) && (addr_dat != 0 || dat_out != 0)) viol++;
    if ((wr_io || rd_io) && (wr_dat || rd_dat)) viol++;
  end

  // Decode tx frames; frames cut by a reset are discarded.
  initial begin
    logic [7:0] b;
    logic st;
    int g;
    forever begin
      @(negedge tx);
      g = rst_gen;
      repeat (8) @(negedge clk);
      st = tx;
      for (int i = 0; i < 8; i++) begin repeat (16) @(negedge clk); b[i] = tx; end
      repeat (16) @(negedge clk);
      if (g == rst_gen && !st && tx) txq.push_back(b);
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 0; repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (16) @(negedge clk); end
    rx = stop; repeat (16) @(negedge clk);
    rx = 1; repeat (2) @(negedge clk);
  endtask

  task automatic get_tx(output logic [7:0] b);
    int t = 0;
    while (txq.size() == 0 && t < 800) begin @(negedge clk); t++; end
    b = txq.size() != 0 ? txq.pop_front() : 8'hxx;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 600) begin @(negedge clk); t++; end
  endtask

  task automatic test_reset();
    int seen = 0;
    rst = 1; rx = 0;
    repeat (3) @(negedge clk);
    n_chk++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_chk++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    n_chk++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_busy_err: got %b%b want 00", busy, err); end
    n_chk++; if ({wr_io, rd_io, wr_dat, rd_dat, addr_io, addr_dat, io_out, dat_out} !== '0) begin n_fail++; $display("FAIL reset_bus: got nonzero want 0"); end
    rst = 0;
    repeat (40) @(negedge clk);
    rx = 1;
    repeat (300) begin @(negedge clk); if (busy || err) seen++; end
    n_chk++; if (seen != 0 || txq.size() != 0) begin n_fail++; $display("FAIL reset_low_line: got %0d busy/err cycles %0d bytes want 0 0", seen, txq.size()); end
  endtask

  task automatic test_write_io();
    int w0 = n_wr_io, e0 = n_err;
    logic [7:0] b;
    bus_gnt = 1;
    send_byte(8'h57, 1); send_byte(8'h00, 1); send_byte(8'h25, 1); send_byte(8'hA5, 1);
    get_tx(b);
    n_chk++; if (b !== 8'h06) begin n_fail++; $display("FAIL write_resp: got %h want 06", b); end
    n_chk++; if (n_wr_io - w0 != 1) begin n_fail++; $display("FAIL write_pulses: got %0d want 1", n_wr_io - w0); end
    n_chk++; if (la_io !== 16'h0025) begin n_fail++; $display("FAIL write_addr: got %h want 0025", la_io); end
    n_chk++; if (lo_io !== 8'hA5) begin n_fail++; $display("FAIL write_data: got %h want a5", lo_io); end
    n_chk++; if (n_err != e0) begin n_fail++; $display("FAIL write_err: got %0d want 0", n_err - e0); end
    wait_idle();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_read_dat();
    int r0 = n_rd_dat, i0 = n_rd_io;
    logic [7:0] b;
    dat_in = 8'h3C;
    send_byte(8'h52, 1); send_byte(8'h00, 1); send_byte(8'hC1, 1);
    get_tx(b);
    n_chk++; if (b !== 8'h3C) begin n_fail++; $display("FAIL read_resp: got %h want 3c", b); end
    n_chk++; if (n_rd_dat - r0 != 1 || n_rd_io != i0) begin n_fail++; $display("FAIL read_pulses: got dat %0d io %0d want 1 0", n_rd_dat - r0, n_rd_io - i0); end
    n_chk++; if (la_dat !== 8'hC1) begin n_fail++; $display("FAIL read_addr: got %h want c1", la_dat); end
    wait_idle();
  endtask

  task automatic test_gnt_wait();
    int bad = 0, w0 = n_wr_io;
    logic [7:0] b;
    bus_gnt = 0;
    send_byte(8'h57, 1); send_byte(8'h00, 1); send_byte(8'h26, 1); send_byte(8'h5A, 1);
    repeat (50) begin @(negedge clk); if (bus_req !== 1'b1) bad++; end
    n_chk++; if (bad != 0 || n_wr_io != w0) begin n_fail++; $display("FAIL gnt_hold: got %0d low-req cycles %0d strobes want 0 0", bad, n_wr_io - w0); end
    bus_gnt = 1;
    @(negedge clk);
    n_chk++; if (wr_io !== 1'b1 || addr_io !== 16'h0026 || io_out !== 8'h5A) begin n_fail++; $display("FAIL gnt_strobe: got %b %h %h want 1 0026 5a", wr_io, addr_io, io_out); end
    @(negedge clk);
    n_chk++; if (bus_req !== 1'b0 || wr_io !== 1'b0) begin n_fail++; $display("FAIL gnt_release: got req %b wr %b want 0 0", bus_req, wr_io); end
    get_tx(b);
    n_chk++; if (b !== 8'h06) begin n_fail++; $display("FAIL gnt_resp: got %h want 06", b); end
    wait_idle();
  endtask

  task automatic test_bad_bytes();
    int e0 = n_err;
    logic [7:0] b;
    send_byte(8'h41, 1);
    get_tx(b);
    n_chk++; if (b !== 8'h15) begin n_fail++; $display("FAIL badop_resp: got %h want 15", b); end
    n_chk++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL badop_err: got %0d want 1", n_err - e0); end
    wait_idle();
    e0 = n_err;
    send_byte(8'h52, 0);
    repeat (20) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badstop_idle: got busy %b want 0", busy); end
    repeat (300) @(negedge clk);
    n_chk++; if (n_err - e0 != 1 || txq.size() != 0) begin n_fail++; $display("FAIL badstop: got err %0d bytes %0d want 1 0", n_err - e0, txq.size()); end
  endtask

  task automatic test_timeout();
    int e0 = n_err, lat = 0, r0 = n_rd_io;
    logic [7:0] b;
    send_byte(8'h57, 1); send_byte(8'h00, 1);
    while (tx !== 1'b0 && lat < 400) begin @(negedge clk); lat++; end
    n_chk++; if (lat < 85 || lat > 110) begin n_fail++; $display("FAIL tmo_latency: got %0d want 85..110", lat); end
    get_tx(b);
    n_chk++; if (b !== 8'h15) begin n_fail++; $display("FAIL tmo_resp: got %h want 15", b); end
    n_chk++; if (n_err - e0 != 1) begin n_fail++; $display("FAIL tmo_err: got %0d want 1", n_err - e0); end
    wait_idle();
    io_in = 8'h99;
    send_byte(8'h52, 1); send_byte(8'h00, 1); send_byte(8'h10, 1);
    get_tx(b);
    n_chk++; if (b !== 8'h99 || n_rd_io - r0 != 1 || la_io !== 16'h0010) begin n_fail++; $display("FAIL tmo_recover: got %h %0d %h want 99 1 0010", b, n_rd_io - r0, la_io); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int low = 0, t = 0;
    bus_gnt = 0;
    send_byte(8'h57, 1); send_byte(8'h00, 1); send_byte(8'h30, 1); send_byte(8'h11, 1);
    repeat (5) @(negedge clk);
    bus_gnt = 1;
    @(negedge clk);
    n_chk++; if (wr_io !== 1'b1) begin n_fail++; $display("FAIL rstacc_pre: got %b want 1", wr_io); end
    rst = 1; #1;
    n_chk++; if ({wr_io, addr_io, io_out, bus_req, busy, err} !== '0 || tx !== 1'b1) begin n_fail++; $display("FAIL rstacc_out: got wr %b req %b busy %b tx %b want 0 0 0 1", wr_io, bus_req, busy, tx); end
    @(negedge clk); rst = 0;
    repeat (300) begin @(negedge clk); if (!tx) low++; end
    n_chk++; if (low != 0 || txq.size() != 0) begin n_fail++; $display("FAIL rstacc_quiet: got %0d low %0d bytes want 0 0", low, txq.size()); end
    send_byte(8'h41, 1);
    while (tx !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    repeat (40) @(negedge clk);
    rst = 1; #1;
    n_chk++; if (tx !== 1'b1 || busy !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL rsttx_out: got tx %b busy %b req %b want 1 0 0", tx, busy, bus_req); end
    @(negedge clk); rst = 0;
    low = 0;
    repeat (400) begin @(negedge clk); if (!tx) low++; end
    n_chk++; if (low != 0 || txq.size() != 0) begin n_fail++; $display("FAIL rsttx_quiet: got %0d low %0d bytes want 0 0", low, txq.size()); end
  endtask

  initial begin
    test_reset();
    test_write_io();
    test_read_dat();
    test_gnt_wait();
    test_bad_bytes();
    test_timeout();
    test_reset_mid();
    n_chk++; if (viol != 0) begin n_fail++; $display("FAIL bus_idle_zero: got %0d violations want 0", viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
